// File: rtl/id_fwd_stage_pkg.sv
// rtl/id_fwd_stage_pkg.sv - opcode, funct, aluop and alusel codes for the decode stage
package id_fwd_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
    localparam logic [5:0] EXE_ANDI         = 6'b001100;
    localparam logic [5:0] EXE_ORI          = 6'b001101;
    localparam logic [5:0] EXE_XORI         = 6'b001110;
    localparam logic [5:0] EXE_LUI          = 6'b001111;

    // SPECIAL funct codes
    localparam logic [5:0] EXE_SLL  = 6'b000000;
    localparam logic [5:0] EXE_SRL  = 6'b000010;
    localparam logic [5:0] EXE_SRA  = 6'b000011;
    localparam logic [5:0] EXE_SLLV = 6'b000100;
    localparam logic [5:0] EXE_SRLV = 6'b000110;
    localparam logic [5:0] EXE_SRAV = 6'b000111;
    localparam logic [5:0] EXE_AND  = 6'b100100;
    localparam logic [5:0] EXE_OR   = 6'b100101;
    localparam logic [5:0] EXE_XOR  = 6'b100110;
    localparam logic [5:0] EXE_NOR  = 6'b100111;

    // ALU operations
    localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP = 8'b00000011;

    // Result selectors
    typedef enum logic [2:0] {
        EXE_RES_NOP   = 3'b000,
        EXE_RES_LOGIC = 3'b001,
        EXE_RES_SHIFT = 3'b010
    } alusel_e;

endpackage

// File: rtl/id_fwd_mux.sv
// rtl/id_fwd_mux.sv - operand select for one read port: r0, prioritised bypass, regfile, immediate
module id_fwd_mux
    import id_fwd_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 2
) (
    input  logic                           read_i,
    input  logic [REG_ADDR_W-1:0]          addr_i,
    input  logic [DATA_W-1:0]              imm_i,
    input  logic [DATA_W-1:0]              reg_data_i,
    input  logic [NUM_FWD-1:0]             fwd_wreg_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0]  fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0]      fwd_wdata_i,
    input  logic [NUM_FWD-1:0]             fwd_pend_i,
    output logic [DATA_W-1:0]              data_o,
    output logic                           hit_o,
    output logic                           pend_o
);

    // Walk sources oldest to youngest so the youngest match is the one left standing
    always_comb begin
        data_o = imm_i;
        hit_o  = 1'b0;
        pend_o = 1'b0;
        if (read_i) begin
            if (addr_i == '0) begin
                data_o = '0;
            end else begin
                data_o = reg_data_i;
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (fwd_wreg_i[k] && (fwd_wd_i[k*REG_ADDR_W +: REG_ADDR_W] == addr_i)) begin
                        data_o = fwd_wdata_i[k*DATA_W +: DATA_W];
                        hit_o  = 1'b1;
                        pend_o = fwd_pend_i[k];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// rtl/id_fwd_stage.sv - MIPS32 logic/shift decode with bypass, load-use stall and ID/EX register
module id_fwd_stage
    import id_fwd_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid_i,
    input  logic [31:0]                    pc_i,
    input  logic [31:0]                    inst_i,
    input  logic [NUM_FWD-1:0]             fwd_wreg_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0]  fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0]      fwd_wdata_i,
    input  logic [NUM_FWD-1:0]             fwd_pend_i,
    input  logic [DATA_W-1:0]              reg1_data_i,
    input  logic [DATA_W-1:0]              reg2_data_i,
    output logic                           reg1_read_o,
    output logic                           reg2_read_o,
    output logic [REG_ADDR_W-1:0]          reg1_addr_o,
    output logic [REG_ADDR_W-1:0]          reg2_addr_o,
    input  logic                           ex_stall_i,
    input  logic                           flush_i,
    output logic                           stall_req_o,
    output logic                           ex_valid_o,
    output logic [31:0]                    ex_pc_o,
    output logic [7:0]                     ex_aluop_o,
    output logic [2:0]                     ex_alusel_o,
    output logic [DATA_W-1:0]              ex_reg1_o,
    output logic [DATA_W-1:0]              ex_reg2_o,
    output logic [REG_ADDR_W-1:0]          ex_wd_o,
    output logic                           ex_wreg_o,
    output logic                           ex_inst_err_o,
    output logic [CNT_W-1:0]               stall_cnt_o
);

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    logic                  dec_r1_read;
    logic                  dec_r2_read;
    logic [DATA_W-1:0]     dec_imm1;
    logic [DATA_W-1:0]     dec_imm2;
    logic [7:0]            dec_aluop;
    alusel_e               dec_alusel;
    logic [REG_ADDR_W-1:0] dec_wd;
    logic                  dec_wreg;
    logic                  dec_err;

    // Instruction decode; an invalid slot reads nothing and decodes as a plain bubble
    always_comb begin
        dec_r1_read = 1'b0;
        dec_r2_read = 1'b0;
        dec_imm1    = '0;
        dec_imm2    = '0;
        dec_aluop   = EXE_NOP_OP;
        dec_alusel  = EXE_RES_NOP;
        dec_wd      = '0;
        dec_wreg    = 1'b0;
        dec_err     = 1'b0;
        if (id_valid_i) begin
            case (op)
                EXE_ORI, EXE_ANDI, EXE_XORI: begin
                    dec_r1_read = 1'b1;
                    dec_imm2    = DATA_W'({16'h0, imm16});
                    dec_wd      = REG_ADDR_W'(rt);
                    dec_wreg    = 1'b1;
                    dec_alusel  = EXE_RES_LOGIC;
                    dec_aluop   = (op == EXE_ORI)  ? EXE_OR_OP  :
                                  (op == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
                end
                EXE_LUI: begin
                    dec_imm2   = DATA_W'({imm16, 16'h0});
                    dec_wd     = REG_ADDR_W'(rt);
                    dec_wreg   = 1'b1;
                    dec_alusel = EXE_RES_LOGIC;
                    dec_aluop  = EXE_OR_OP;
                end
                EXE_SPECIAL_INST: begin
                    dec_wd = REG_ADDR_W'(rd);
                    case (funct)
                        EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
                            dec_r1_read = 1'b1;
                            dec_r2_read = 1'b1;
                            dec_wreg    = 1'b1;
                            dec_alusel  = EXE_RES_LOGIC;
                            dec_aluop   = (funct == EXE_AND) ? EXE_AND_OP :
                                          (funct == EXE_OR)  ? EXE_OR_OP  :
                                          (funct == EXE_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
                        end
                        EXE_SLLV, EXE_SRLV, EXE_SRAV: begin
                            dec_r1_read = 1'b1;
                            dec_r2_read = 1'b1;
                            dec_wreg    = 1'b1;
                            dec_alusel  = EXE_RES_SHIFT;
                            dec_aluop   = (funct == EXE_SLLV) ? EXE_SLL_OP :
                                          (funct == EXE_SRLV) ? EXE_SRL_OP : EXE_SRA_OP;
                        end
                        EXE_SLL, EXE_SRL, EXE_SRA: begin
                            // The all-zero word is the canonical nop: legal, writes nothing
                            if (inst_i != 32'h0) begin
                                dec_r2_read = 1'b1;
                                dec_imm1    = DATA_W'(sa);
                                dec_wreg    = 1'b1;
                                dec_alusel  = EXE_RES_SHIFT;
                                dec_aluop   = (funct == EXE_SLL) ? EXE_SLL_OP :
                                              (funct == EXE_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
                            end else begin
                                dec_wd = '0;
                            end
                        end
                        default: begin
                            dec_wd  = '0;
                            dec_err = 1'b1;
                        end
                    endcase
                end
                default: begin
                    dec_err = 1'b1;
                end
            endcase
        end
    end

    assign reg1_read_o = dec_r1_read;
    assign reg2_read_o = dec_r2_read;
    assign reg1_addr_o = REG_ADDR_W'(rs);
    assign reg2_addr_o = REG_ADDR_W'(rt);

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              hit1;
    logic              hit2;
    logic              pend1;
    logic              pend2;

    id_fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) u_mux1 (
        .read_i      (dec_r1_read),
        .addr_i      (reg1_addr_o),
        .imm_i       (dec_imm1),
        .reg_data_i  (reg1_data_i),
        .fwd_wreg_i  (fwd_wreg_i),
        .fwd_wd_i    (fwd_wd_i),
        .fwd_wdata_i (fwd_wdata_i),
        .fwd_pend_i  (fwd_pend_i),
        .data_o      (op1),
        .hit_o       (hit1),
        .pend_o      (pend1)
    );

    id_fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) u_mux2 (
        .read_i      (dec_r2_read),
        .addr_i      (reg2_addr_o),
        .imm_i       (dec_imm2),
        .reg_data_i  (reg2_data_i),
        .fwd_wreg_i  (fwd_wreg_i),
        .fwd_wd_i    (fwd_wd_i),
        .fwd_wdata_i (fwd_wdata_i),
        .fwd_pend_i  (fwd_pend_i),
        .data_o      (op2),
        .hit_o       (hit2),
        .pend_o      (pend2)
    );

    // A load-use hazard only matters when this slot would actually advance into ex
    assign stall_req_o = id_valid_i & ~ex_stall_i & ((hit1 & pend1) | (hit2 & pend2));

    logic                  ex_valid_q,    ex_valid_d;
    logic [31:0]           ex_pc_q,       ex_pc_d;
    logic [7:0]            ex_aluop_q,    ex_aluop_d;
    logic [2:0]            ex_alusel_q,   ex_alusel_d;
    logic [DATA_W-1:0]     ex_reg1_q,     ex_reg1_d;
    logic [DATA_W-1:0]     ex_reg2_q,     ex_reg2_d;
    logic [REG_ADDR_W-1:0] ex_wd_q,       ex_wd_d;
    logic                  ex_wreg_q,     ex_wreg_d;
    logic                  ex_inst_err_q, ex_inst_err_d;
    logic [CNT_W-1:0]      stall_cnt_q,   stall_cnt_d;

    // Next ID/EX contents: flush beats hold, hold beats the hazard bubble, bubble beats load
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_aluop_d    = ex_aluop_q;
        ex_alusel_d   = ex_alusel_q;
        ex_reg1_d     = ex_reg1_q;
        ex_reg2_d     = ex_reg2_q;
        ex_wd_d       = ex_wd_q;
        ex_wreg_d     = ex_wreg_q;
        ex_inst_err_d = ex_inst_err_q;
        stall_cnt_d   = stall_cnt_q;
        if (flush_i || (!ex_stall_i && (stall_req_o || !id_valid_i))) begin
            ex_valid_d    = 1'b0;
            ex_pc_d       = '0;
            ex_aluop_d    = EXE_NOP_OP;
            ex_alusel_d   = EXE_RES_NOP;
            ex_reg1_d     = '0;
            ex_reg2_d     = '0;
            ex_wd_d       = '0;
            ex_wreg_d     = 1'b0;
            ex_inst_err_d = 1'b0;
        end else if (!ex_stall_i) begin
            ex_valid_d    = 1'b1;
            ex_pc_d       = pc_i;
            ex_aluop_d    = dec_aluop;
            ex_alusel_d   = dec_alusel;
            ex_reg1_d     = op1;
            ex_reg2_d     = op2;
            ex_wd_d       = dec_wd;
            ex_wreg_d     = dec_wreg;
            ex_inst_err_d = dec_err;
        end
        if (!flush_i && stall_req_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // ID/EX pipeline register and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_aluop_q    <= EXE_NOP_OP;
            ex_alusel_q   <= EXE_RES_NOP;
            ex_reg1_q     <= '0;
            ex_reg2_q     <= '0;
            ex_wd_q       <= '0;
            ex_wreg_q     <= 1'b0;
            ex_inst_err_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_alusel_q   <= ex_alusel_d;
            ex_reg1_q     <= ex_reg1_d;
            ex_reg2_q     <= ex_reg2_d;
            ex_wd_q       <= ex_wd_d;
            ex_wreg_q     <= ex_wreg_d;
            ex_inst_err_q <= ex_inst_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_aluop_o    = ex_aluop_q;
    assign ex_alusel_o   = ex_alusel_q;
    assign ex_reg1_o     = ex_reg1_q;
    assign ex_reg2_o     = ex_reg2_q;
    assign ex_wd_o       = ex_wd_q;
    assign ex_wreg_o     = ex_wreg_q;
    assign ex_inst_err_o = ex_inst_err_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// tb/tb_id_fwd_stage.sv - self-checking bench for id_fwd_stage
module tb_id_fwd_stage;

    localparam int NF = 2;
    localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27, OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
    localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2;

    logic        clk = 1'b0;
    logic        rst, id_valid_i, ex_stall_i, flush_i;
    logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i;
    logic        fw_wreg [NF];
    logic [4:0]  fw_wd   [NF];
    logic [31:0] fw_data [NF];
    logic        fw_pend [NF];
    logic [1:0]  fwd_wreg_i, fwd_pend_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic        reg1_read_o, reg2_read_o, stall_req_o, ex_valid_o, ex_wreg_o, ex_inst_err_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o, ex_wd_o;
    logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [15:0] stall_cnt_o;

    assign fwd_wreg_i  = {fw_wreg[1], fw_wreg[0]};
    assign fwd_pend_i  = {fw_pend[1], fw_pend[0]};
    assign fwd_wd_i    = {fw_wd[1], fw_wd[0]};
    assign fwd_wdata_i = {fw_data[1], fw_data[0]};

    id_fwd_stage dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .ex_stall_i(ex_stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
        .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_inst_err_o(ex_inst_err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        err;
    } ex_t;

    function automatic ex_t bubble();
        ex_t e;
        e.valid = 1'b0; e.pc = '0; e.aluop = OP_NOP; e.alusel = SEL_NOP;
        e.r1 = '0; e.r2 = '0; e.wd = '0; e.wreg = 1'b0; e.err = 1'b0;
        return e;
    endfunction

    task automatic check_ex(input string tag, input ex_t e);
        chk({tag, ".valid"},  32'(ex_valid_o),    32'(e.valid));
        chk({tag, ".pc"},     ex_pc_o,            e.pc);
        chk({tag, ".aluop"},  32'(ex_aluop_o),    32'(e.aluop));
        chk({tag, ".alusel"}, 32'(ex_alusel_o),   32'(e.alusel));
        chk({tag, ".reg1"},   ex_reg1_o,          e.r1);
        chk({tag, ".reg2"},   ex_reg2_o,          e.r2);
        chk({tag, ".wd"},     32'(ex_wd_o),       32'(e.wd));
        chk({tag, ".wreg"},   32'(ex_wreg_o),     32'(e.wreg));
        chk({tag, ".err"},    32'(ex_inst_err_o), 32'(e.err));
    endtask

    task automatic set_fwd(input logic [1:0] wr, input logic [4:0] wd0, input logic [31:0] d0, input logic p0,
                           input logic [4:0] wd1, input logic [31:0] d1, input logic p1);
        fw_wreg[0] = wr[0]; fw_wd[0] = wd0; fw_data[0] = d0; fw_pend[0] = p0;
        fw_wreg[1] = wr[1]; fw_wd[1] = wd1; fw_data[1] = d1; fw_pend[1] = p1;
    endtask

    // Reference decode: what the instruction word means, independent of forwarding
    function automatic void ref_decode(input logic [31:0] w, output logic r1r, output logic r2r,
                                       output logic [31:0] i1, output logic [31:0] i2, output ex_t d);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        d = bubble();
        r1r = 1'b0; r2r = 1'b0; i1 = '0; i2 = '0;
        if (op == 6'h0D || op == 6'h0C || op == 6'h0E) begin
            r1r = 1'b1; i2 = {16'h0, w[15:0]}; d.wd = w[20:16]; d.wreg = 1'b1; d.alusel = SEL_LOGIC;
            d.aluop = (op == 6'h0D) ? OP_OR : (op == 6'h0C) ? OP_AND : OP_XOR;
        end else if (op == 6'h0F) begin
            i2 = {w[15:0], 16'h0}; d.wd = w[20:16]; d.wreg = 1'b1; d.alusel = SEL_LOGIC; d.aluop = OP_OR;
        end else if (op == 6'h00 && w == 32'h0) begin
            d.err = 1'b0;
        end else if (op == 6'h00 && fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
            r1r = 1'b1; r2r = 1'b1; d.wd = w[15:11]; d.wreg = 1'b1; d.alusel = SEL_LOGIC;
            d.aluop = (fn == 6'h24) ? OP_AND : (fn == 6'h25) ? OP_OR : (fn == 6'h26) ? OP_XOR : OP_NOR;
        end else if (op == 6'h00 && fn inside {6'h04, 6'h06, 6'h07}) begin
            r1r = 1'b1; r2r = 1'b1; d.wd = w[15:11]; d.wreg = 1'b1; d.alusel = SEL_SHIFT;
            d.aluop = (fn == 6'h04) ? OP_SLL : (fn == 6'h06) ? OP_SRL : OP_SRA;
        end else if (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03}) begin
            r2r = 1'b1; i1 = {27'b0, w[10:6]}; d.wd = w[15:11]; d.wreg = 1'b1; d.alusel = SEL_SHIFT;
            d.aluop = (fn == 6'h00) ? OP_SLL : (fn == 6'h02) ? OP_SRL : OP_SRA;
        end else begin
            d.err = 1'b1;
        end
    endfunction

    // Reference operand: first live bypass source that names the register wins
    function automatic logic [31:0] resolve(input logic rd, input logic [4:0] a, input logic [31:0] imm,
                                            input logic [31:0] rf, output logic pend);
        pend = 1'b0;
        if (!rd) return imm;
        if (a == 5'd0) return 32'h0;
        for (int k = 0; k < NF; k++) begin
            if (fw_wreg[k] && fw_wd[k] == a) begin
                pend = fw_pend[k];
                return fw_data[k];
            end
        end
        return rf;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  wr;
        logic [4:0]  wd0;
        logic [31:0] d0;
        logic [4:0]  wd1;
        logic [31:0] d1;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  ewd;
        logic        ewreg;
        logic        eerr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ex_t e, m_cur, m_nxt, dec;
        logic [15:0] m_cnt;
        logic r1r, r2r, p1, p2, hz;
        logic [31:0] i1, i2, o1, o2;

        // Reset with ori $1,$0,0x1100 waiting at the input
        rst = 1'b1; id_valid_i = 1'b1; pc_i = 32'h40; inst_i = 32'h34011100;
        ex_stall_i = 1'b0; flush_i = 1'b0; reg1_data_i = '0; reg2_data_i = '0;
        set_fwd(2'b00, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_ex("rst", bubble());
            chk("rst.cnt", 32'(stall_cnt_o), 32'h0);
        end
        rst = 1'b0;
        #2;
        chk("ori.r1read", 32'(reg1_read_o), 32'h1);
        chk("ori.r2read", 32'(reg2_read_o), 32'h0);
        chk("ori.r2addr", 32'(reg2_addr_o), 32'h1);
        @(posedge clk); #1;
        e = bubble(); e.valid = 1'b1; e.pc = 32'h40; e.aluop = OP_OR; e.alusel = SEL_LOGIC;
        e.r2 = 32'h1100; e.wd = 5'd1; e.wreg = 1'b1;
        check_ex("rst_release", e);

        // Load-use: or $3,$1,$2 with $2 still in flight from ex
        pc_i = 32'h100; inst_i = 32'h00221825; reg1_data_i = 32'h11; reg2_data_i = 32'h22;
        set_fwd(2'b01, 5'd2, 32'hBAD, 1'b1, 5'd0, 32'h0, 1'b0);
        #2;
        chk("lu.stall_req", 32'(stall_req_o), 32'h1);
        @(posedge clk); #1;
        chk("lu.bubble_valid", 32'(ex_valid_o), 32'h0);
        chk("lu.cnt", 32'(stall_cnt_o), 32'h1);
        set_fwd(2'b01, 5'd2, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        chk("lu.stall_clear", 32'(stall_req_o), 32'h0);
        @(posedge clk); #1;
        e = bubble(); e.valid = 1'b1; e.pc = 32'h100; e.aluop = OP_OR; e.alusel = SEL_LOGIC;
        e.r1 = 32'h11; e.r2 = 32'h7; e.wd = 5'd3; e.wreg = 1'b1;
        check_ex("lu.load", e);

        // Hold two cycles with a hazard present, then flush during the hold
        pc_i = 32'h200;
        set_fwd(2'b01, 5'd2, 32'hBAD, 1'b1, 5'd0, 32'h0, 1'b0);
        ex_stall_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("hold.stall_req", 32'(stall_req_o), 32'h0);
            @(posedge clk); #1;
            check_ex("hold", e);
            chk("hold.cnt", 32'(stall_cnt_o), 32'h1);
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        check_ex("flush", bubble());
        flush_i = 1'b0; ex_stall_i = 1'b0;
        #2;
        chk("after_hold.stall_req", 32'(stall_req_o), 32'h1);
        @(posedge clk); #1;
        chk("after_hold.cnt", 32'(stall_cnt_o), 32'h2);

        // Pending older source shadowed by a ready younger one
        set_fwd(2'b11, 5'd2, 32'h9, 1'b0, 5'd2, 32'hBAD, 1'b1);
        #2;
        chk("shadow.stall_req", 32'(stall_req_o), 32'h0);
        @(posedge clk); #1;
        chk("shadow.reg2", ex_reg2_o, 32'h9);
        chk("shadow.cnt", 32'(stall_cnt_o), 32'h2);

        // Reset while a hazard is present
        set_fwd(2'b01, 5'd2, 32'hBAD, 1'b1, 5'd0, 32'h0, 1'b0);
        rst = 1'b1;
        #2;
        chk("rst_mid.stall_req", 32'(stall_req_o), 32'h1);
        @(posedge clk); #1;
        chk("rst_mid.cnt", 32'(stall_cnt_o), 32'h0);
        chk("rst_mid.valid", 32'(ex_valid_o), 32'h0);
        rst = 1'b0;

        // Single-cycle decode/forwarding vectors
        vecs[0]  = '{32'h34220020, 2'b11, 5'd1, 32'h1100, 5'd1, 32'hDEAD, 32'h0,  32'h0,  OP_OR,  SEL_LOGIC, 32'h1100, 32'h20, 5'd2, 1'b1, 1'b0};
        vecs[1]  = '{32'h34220020, 2'b10, 5'd1, 32'h1100, 5'd1, 32'hDEAD, 32'h0,  32'h0,  OP_OR,  SEL_LOGIC, 32'hDEAD, 32'h20, 5'd2, 1'b1, 1'b0};
        vecs[2]  = '{32'h34220020, 2'b00, 5'd1, 32'h1100, 5'd1, 32'hDEAD, 32'h55, 32'h0,  OP_OR,  SEL_LOGIC, 32'h55,   32'h20, 5'd2, 1'b1, 1'b0};
        vecs[3]  = '{32'h00001025, 2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0,    32'h3,  32'h4,  OP_OR,  SEL_LOGIC, 32'h0,    32'h0,  5'd2, 1'b1, 1'b0};
        vecs[4]  = '{32'hFC000000, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    32'h3,  32'h4,  OP_NOP, SEL_NOP,   32'h0,    32'h0,  5'd0, 1'b0, 1'b1};
        vecs[5]  = '{32'h00021100, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    32'h3,  32'h12, OP_SLL, SEL_SHIFT, 32'h4,    32'h12, 5'd2, 1'b1, 1'b0};
        vecs[6]  = '{32'h3C01ABCD, 2'b01, 5'd0, 32'h99,   5'd0, 32'h0,    32'h3,  32'h4,  OP_OR,  SEL_LOGIC, 32'h0,    32'hABCD0000, 5'd1, 1'b1, 1'b0};
        vecs[7]  = '{32'h00000000, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    32'h3,  32'h4,  OP_NOP, SEL_NOP,   32'h0,    32'h0,  5'd0, 1'b0, 1'b0};
        vecs[8]  = '{32'h00432024, 2'b01, 5'd3, 32'h33,   5'd0, 32'h0,    32'h22, 32'h44, OP_AND, SEL_LOGIC, 32'h22,   32'h33, 5'd4, 1'b1, 1'b0};
        vecs[9]  = '{32'h3822FFFF, 2'b10, 5'd0, 32'h0,    5'd1, 32'h77,   32'h3,  32'h4,  OP_XOR, SEL_LOGIC, 32'h77,   32'hFFFF, 5'd2, 1'b1, 1'b0};
        vecs[10] = '{32'h00622007, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,    32'h5,  32'h80, OP_SRA, SEL_SHIFT, 32'h5,    32'h80, 5'd4, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            inst_i = vecs[i].inst; pc_i = 32'h1000 + 32'(i) * 4;
            reg1_data_i = vecs[i].rf1; reg2_data_i = vecs[i].rf2;
            set_fwd(vecs[i].wr, vecs[i].wd0, vecs[i].d0, 1'b0, vecs[i].wd1, vecs[i].d1, 1'b0);
            @(posedge clk); #1;
            e.valid = 1'b1; e.pc = 32'h1000 + 32'(i) * 4; e.aluop = vecs[i].aluop; e.alusel = vecs[i].alusel;
            e.r1 = vecs[i].e1; e.r2 = vecs[i].e2; e.wd = vecs[i].ewd; e.wreg = vecs[i].ewreg; e.err = vecs[i].eerr;
            check_ex($sformatf("vec%0d", i), e);
        end

        // Randomized traffic against the reference model
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cur = bubble(); m_cnt = '0;
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rs, rt, rd;
            int kind;
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 7));
            kind = $urandom_range(0, 15);
            case (kind)
                0:  inst_i = {6'h0D, rs, rt, 16'($urandom)};
                1:  inst_i = {6'h0C, rs, rt, 16'($urandom)};
                2:  inst_i = {6'h0E, rs, rt, 16'($urandom)};
                3:  inst_i = {6'h0F, rs, rt, 16'($urandom)};
                4:  inst_i = {6'h00, rs, rt, rd, 5'd0, 6'h24};
                5:  inst_i = {6'h00, rs, rt, rd, 5'd0, 6'h25};
                6:  inst_i = {6'h00, rs, rt, rd, 5'd0, 6'h26};
                7:  inst_i = {6'h00, rs, rt, rd, 5'd0, 6'h27};
                8:  inst_i = {6'h00, 5'd0, rt, rd, 5'($urandom), 6'h00};
                9:  inst_i = {6'h00, 5'd0, rt, rd, 5'($urandom), 6'h02};
                10: inst_i = {6'h00, 5'd0, rt, rd, 5'($urandom), 6'h03};
                11: inst_i = {6'h00, rs, rt, rd, 5'd0, 6'h04};
                12: inst_i = {6'h00, rs, rt, rd, 5'd0, 6'h06};
                13: inst_i = {6'h00, rs, rt, rd, 5'd0, 6'h07};
                14: inst_i = 32'h0;
                default: inst_i = ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            endcase
            rst         = ($urandom_range(0, 49) == 0);
            id_valid_i  = ($urandom_range(0, 9) != 0);
            ex_stall_i  = ($urandom_range(0, 9) == 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            pc_i        = $urandom;
            reg1_data_i = $urandom;
            reg2_data_i = $urandom;
            for (int k = 0; k < NF; k++) begin
                fw_wreg[k] = 1'($urandom_range(0, 1));
                fw_wd[k]   = 5'($urandom_range(0, 3));
                fw_data[k] = $urandom;
                fw_pend[k] = ($urandom_range(0, 4) == 0);
            end
            #2;
            ref_decode(inst_i, r1r, r2r, i1, i2, dec);
            if (!id_valid_i) begin
                r1r = 1'b0; r2r = 1'b0;
            end
            o1 = resolve(r1r, inst_i[25:21], i1, reg1_data_i, p1);
            o2 = resolve(r2r, inst_i[20:16], i2, reg2_data_i, p2);
            hz = id_valid_i && !ex_stall_i && (p1 || p2);
            chk("rnd.stall_req", 32'(stall_req_o), 32'(hz));
            chk("rnd.r1read", 32'(reg1_read_o), 32'(r1r));
            chk("rnd.r2read", 32'(reg2_read_o), 32'(r2r));
            if (rst) begin
                m_nxt = bubble(); m_cnt = '0;
            end else if (flush_i) begin
                m_nxt = bubble();
            end else if (ex_stall_i) begin
                m_nxt = m_cur;
            end else if (hz) begin
                m_nxt = bubble();
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else if (id_valid_i) begin
                m_nxt = dec; m_nxt.valid = 1'b1; m_nxt.pc = pc_i; m_nxt.r1 = o1; m_nxt.r2 = o2;
            end else begin
                m_nxt = bubble();
            end
            @(posedge clk); #1;
            m_cur = m_nxt;
            check_ex("rnd", m_cur);
            chk("rnd.cnt", 32'(stall_cnt_o), 32'(m_cnt));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/id_fwd_stage.md
Name: id_fwd_stage

Overview:
- Parametrised decode stage with the ID/EX pipeline register built in.
- Decodes the MIPS32 logic and shift subset and resolves operands from NUM_FWD prioritised bypass sources.
- Detects load-use hazards, requests an upstream stall and inserts a bubble.
- Sits between the IF/ID register and ex; drives the regfile read ports combinationally.

Parameters:
- DATA_W, 32, operand/data width
- REG_ADDR_W, 5, register address width
- NUM_FWD, 2, bypass sources; index 0 = youngest (ex), highest priority
- CNT_W, 16, width of saturating load-use bubble counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_valid_i  in  1  inst_i holds a real instruction
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- fwd_wreg_i  in  NUM_FWD  source k writes a register
- fwd_wd_i  in  NUM_FWD*REG_ADDR_W  destination of source k, packed, k=0 in LSBs
- fwd_wdata_i  in  NUM_FWD*DATA_W  result of source k, packed
- fwd_pend_i  in  NUM_FWD  source k result not yet available (load in flight)
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data
- reg1_read_o, reg2_read_o  out  1  read enables (combinational)
- reg1_addr_o, reg2_addr_o  out  REG_ADDR_W  rs / rt (combinational)
- ex_stall_i  in  1  ex cannot accept; hold register
- flush_i  in  1  discard register contents
- stall_req_o  out  1  load-use hazard; upstream must hold IF/ID (combinational)
- ex_valid_o  out  1  registered slot valid
- ex_pc_o  out  32
- ex_aluop_o  out  8
- ex_alusel_o  out  3
- ex_reg1_o, ex_reg2_o  out  DATA_W  resolved operands
- ex_wd_o  out  REG_ADDR_W
- ex_wreg_o  out  1
- ex_inst_err_o  out  1  reserved-instruction flag
- stall_cnt_o  out  CNT_W  bubbles inserted since reset

Behaviour:
- Decode (combinational), aluop/alusel from define.v:
  - ORI/ANDI/XORI: zero-extended imm16; reg1 = rs; wd = rt; LOGIC.
  - LUI: imm = {imm16,16'h0}; reg1 read disabled; operand 1 = 0; OR_OP; wd = rt.
  - SPECIAL AND/OR/XOR/NOR: rs, rt; wd = rd; LOGIC.
  - SLL/SRL/SRA: reg2 = rt; operand 1 = {27'b0, shamt}; wd = rd; SHIFT.
  - SLLV/SRLV/SRAV: rs, rt; SHIFT.
  - SPECIAL funct 0 with word 0 (nop): valid, wreg = 0.
  - Anything else: NOP_OP/RES_NOP, wreg = 0, inst_err = 1.
  - id_valid_i = 0: read enables 0, no hazard, loads a bubble.
- Operand resolution per port, in priority order:
  - read enabled and addr = 0 -> 0 (no forwarding of r0);
  - else lowest k with fwd_wreg_i[k] and matching fwd_wd_i[k] -> fwd_wdata_i[k];
  - else regfile data;
  - read disabled -> imm.
- Hazard:
  - stall_req_o = id_valid_i & !ex_stall_i & (any read port whose first matching source k has fwd_pend_i[k]).
  - A pending older source shadowed by a younger non-pending match does not stall.
- Register update on posedge clk, priority rst > flush_i > ex_stall_i > stall_req_o > load:
  - rst: all ex_* = 0 (aluop NOP, alusel NOP, wd 0), stall_cnt_o = 0.
  - flush_i: bubble (valid/wreg/inst_err = 0, aluop NOP); pc cleared.
  - ex_stall_i: hold all ex_* unchanged; stall_req_o forced 0.
  - stall_req_o: load bubble; stall_cnt_o += 1, saturating at all-ones.
  - else: load decoded fields and resolved operands.
- Latency: inst_i -> ex_* is exactly 1 cycle; forwarding samples sources in the same cycle as decode.
- Rst mid-stall: counter and register clear; stall_req_o still follows its combinational inputs.

Decomposition:
- New EXE_* aluop/alusel/opcode/funct codes go in define.v alongside the existing ones; no local literals.
- Sub-module: id_fwd_mux, one per read port. It performs the r0/priority/regfile/imm selection and returns the hit and pending flags.

Test Plan:
- Reset 3 cycles, inst 0x34011100 valid -> ex_* all 0 during rst; cycle after release: ex_aluop_o=OR_OP, ex_reg2_o=0x00001100, ex_wd_o=1, ex_wreg_o=1.
- Forwarding priority: inst 0x34220020 with fwd0 {wd=1, 0x1100} and fwd1 {wd=1, 0xDEAD} -> ex_reg1_o=0x1100. Drop fwd0 -> 0xDEAD. Drop both with reg1_data_i=0x55 -> 0x55.
- r0 guard: 0x00001025 (or $2,$0,$0) with fwd0 {wd=0, 0xFFFF} -> ex_reg1_o = ex_reg2_o = 0.
- Load-use: 0x00221825 with fwd0 {wd=2, pend=1} -> stall_req_o=1, next ex_valid_o=0, stall_cnt_o=1. Next cycle pend=0, fwd0 data 0x7 -> instruction loads with ex_reg2_o=7.
- Hold/flush: ex_stall_i=1 for 2 cycles while hazard present -> ex_* unchanged, stall_req_o=0, counter unchanged. flush_i together with ex_stall_i -> bubble.
- Illegal opcode 0xFC000000 -> ex_inst_err_o=1, ex_wreg_o=0. SLL 0x00021100 (shamt 4) -> ex_reg1_o=4, alusel SHIFT.
